// File: rtl/bw_clk_gclk_stop_seq.sv
// Global-clock stop/start/step sequencer: walks the cluster clock between
// running, stopped and debug-burst modes and drives a registered gate enable.
module bw_clk_gclk_stop_seq #(
    parameter int DLY_W = 4
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             stop_req,
    input  logic             start_req,
    input  logic             step_req,
    input  logic [DLY_W-1:0] stop_dly,
    input  logic [DLY_W-1:0] start_dly,
    input  logic [DLY_W-1:0] step_len,
    output logic             clk_en,
    output logic             clk_stopped,
    output logic             seq_busy,
    output logic             seq_done
);

    localparam logic [2:0] RUN        = 3'd0;
    localparam logic [2:0] STOP_WAIT  = 3'd1;
    localparam logic [2:0] STOPPED    = 3'd2;
    localparam logic [2:0] START_WAIT = 3'd3;
    localparam logic [2:0] STEP       = 3'd4;

    localparam logic [DLY_W-1:0] CNT_ONE = {{(DLY_W-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [DLY_W-1:0] cnt;
    logic [DLY_W-1:0] cnt_nxt;
    logic             done_pend;
    logic             done_nxt;

    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            RUN: begin
                if (stop_req) begin
                    state_nxt = STOP_WAIT;
                    cnt_nxt   = stop_dly;
                end
            end
            STOP_WAIT: begin
                if (start_req) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = STOPPED;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            STOPPED: begin
                // Restart outranks a step burst when both arrive together.
                if (start_req) begin
                    state_nxt = START_WAIT;
                    cnt_nxt   = start_dly;
                end else if (step_req) begin
                    state_nxt = STEP;
                    cnt_nxt   = step_len;
                end
            end
            START_WAIT: begin
                if (stop_req) begin
                    state_nxt = STOPPED;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = RUN;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            STEP: begin
                if (cnt == '0) begin
                    state_nxt = STOPPED;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge rclk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            done_pend   <= 1'b0;
            clk_en      <= 1'b1;
            clk_stopped <= 1'b0;
            seq_busy    <= 1'b0;
            seq_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            done_pend   <= done_nxt;
            // Outputs decode the settled state one edge later: pure flops,
            // no input reaches clk_en combinationally.
            clk_en      <= (state == RUN) || (state == STOP_WAIT) || (state == STEP);
            clk_stopped <= (state == STOPPED);
            seq_busy    <= (state == STOP_WAIT) || (state == START_WAIT) || (state == STEP);
            seq_done    <= done_pend;
        end
    end

endmodule

// File: tb/tb_bw_clk_gclk_stop_seq.sv
// Self-checking bench: deadline-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bw_clk_gclk_stop_seq;

    localparam int DLY_W = 4;

    logic             rclk = 1'b0;
    logic             reset;
    logic             stop_req, start_req, step_req;
    logic [DLY_W-1:0] stop_dly, start_dly, step_len;
    logic             clk_en, clk_stopped, seq_busy, seq_done;

    bw_clk_gclk_stop_seq #(.DLY_W(DLY_W)) dut (
        .rclk        (rclk),
        .reset       (reset),
        .stop_req    (stop_req),
        .start_req   (start_req),
        .step_req    (step_req),
        .stop_dly    (stop_dly),
        .start_dly   (start_dly),
        .step_len    (step_len),
        .clk_en      (clk_en),
        .clk_stopped (clk_stopped),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done)
    );

    always #5 rclk = ~rclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: each mode change schedules an absolute edge number at
    // which it completes; observed outputs trail the mode by one edge.
    typedef enum int {M_RUN, M_STOP_WAIT, M_STOPPED, M_START_WAIT, M_STEP} mode_t;
    mode_t mode;
    int    edge_no = 0;
    int    deadline = 0;
    bit    done_p = 1'b0;
    bit    model_valid = 1'b0;
    logic  e_en, e_stp, e_busy, e_done;

    always @(posedge rclk) begin
        edge_no++;
        if (reset) begin
            mode = M_RUN;
            done_p = 1'b0;
            e_en = 1'b1; e_stp = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            e_en   = (mode == M_RUN) || (mode == M_STOP_WAIT) || (mode == M_STEP);
            e_stp  = (mode == M_STOPPED);
            e_busy = (mode == M_STOP_WAIT) || (mode == M_START_WAIT) || (mode == M_STEP);
            e_done = done_p;
            done_p = 1'b0;
            case (mode)
                M_RUN: if (stop_req) begin
                    mode = M_STOP_WAIT;
                    deadline = edge_no + int'(stop_dly) + 1;
                end
                M_STOP_WAIT: if (start_req) mode = M_RUN;
                    else if (edge_no == deadline) begin mode = M_STOPPED; done_p = 1'b1; end
                M_STOPPED: if (start_req) begin
                    mode = M_START_WAIT;
                    deadline = edge_no + int'(start_dly) + 1;
                end else if (step_req) begin
                    mode = M_STEP;
                    deadline = edge_no + int'(step_len) + 1;
                end
                M_START_WAIT: if (stop_req) mode = M_STOPPED;
                    else if (edge_no == deadline) begin mode = M_RUN; done_p = 1'b1; end
                M_STEP: if (edge_no == deadline) begin mode = M_STOPPED; done_p = 1'b1; end
                default: mode = M_RUN;
            endcase
        end
    end

    always @(negedge rclk) begin
        if (model_valid) begin
            check("model clk_en",      clk_en,      e_en);
            check("model clk_stopped", clk_stopped, e_stp);
            check("model seq_busy",    seq_busy,    e_busy);
            check("model seq_done",    seq_done,    e_done);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge rclk);
    endtask

    // Drives one request pulse; returns at the negedge after the sampling edge.
    task automatic pulse(input bit s, input bit g, input bit p);
        stop_req = s; start_req = g; step_req = p;
        @(negedge rclk);
        stop_req = 1'b0; start_req = 1'b0; step_req = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic en, input logic stp,
                              input logic busy, input logic done);
        check({tag, " clk_en"},      clk_en,      en);
        check({tag, " clk_stopped"}, clk_stopped, stp);
        check({tag, " seq_busy"},    seq_busy,    busy);
        check({tag, " seq_done"},    seq_done,    done);
    endtask

    task automatic stop_seq_dly3(input string tag);
        stop_dly = 4'd3;
        pulse(1, 0, 0);
        for (int j = 1; j <= 6; j++) begin
            idle(1);
            expect_out($sformatf("%s j%0d", tag, j), j < 5, j >= 5, j < 5, j == 5);
        end
    endtask

    initial begin
        reset = 1'b1;
        stop_req = 1'b0; start_req = 1'b0; step_req = 1'b0;
        stop_dly = '0; start_dly = '0; step_len = '0;
        idle(2);
        expect_out("reset", 1, 0, 0, 0);
        reset = 1'b0;
        idle(3);

        stop_seq_dly3("stop3");

        start_dly = 4'd0;
        pulse(0, 1, 0);
        idle(1); expect_out("start0 j1", 0, 0, 1, 0);
        idle(1); expect_out("start0 j2", 1, 0, 0, 1);
        idle(1); expect_out("start0 j3", 1, 0, 0, 0);

        stop_dly = 4'd0;
        pulse(1, 0, 0);
        idle(3); expect_out("stop0 settled", 0, 1, 0, 0);

        step_len = 4'd2;
        pulse(0, 0, 1);
        for (int j = 1; j <= 4; j++) begin
            idle(1);
            expect_out($sformatf("step2 j%0d", j), j < 4, j == 4, j < 4, j == 4);
        end
        step_len = 4'd0;
        pulse(0, 0, 1);
        idle(1); expect_out("step0 j1", 1, 0, 1, 0);
        idle(1); expect_out("step0 j2", 0, 1, 0, 1);

        start_dly = 4'd3; step_len = 4'd3;
        pulse(0, 1, 1);
        idle(1); expect_out("prio j1", 0, 0, 1, 0);
        idle(1); expect_out("prio j2", 0, 0, 1, 0);
        idle(3); expect_out("prio j5", 1, 0, 0, 1);

        stop_dly = 4'd5;
        pulse(1, 0, 0);
        idle(1);
        pulse(0, 1, 0);
        for (int j = 1; j <= 4; j++) begin
            idle(1);
            expect_out($sformatf("abort j%0d", j), 1, 0, 0, 0);
        end

        stop_dly = 4'd15;
        pulse(1, 0, 0);
        idle(16); expect_out("stop15 j16", 1, 0, 1, 0);
        idle(1);  expect_out("stop15 j17", 0, 1, 0, 1);
        start_dly = 4'd0;
        pulse(0, 1, 0);
        idle(3);

        stop_dly = 4'd3;
        pulse(1, 0, 0);
        stop_dly = 4'd0;
        idle(4); expect_out("midchg j4", 1, 0, 1, 0);
        idle(1); expect_out("midchg j5", 0, 1, 0, 1);

        step_len = 4'd3;
        pulse(0, 0, 1);
        pulse(0, 1, 0);
        idle(3); expect_out("stepdrop j4", 1, 0, 1, 0);
        idle(1); expect_out("stepdrop j5", 0, 1, 0, 1);
        idle(2); expect_out("stepdrop j7", 0, 1, 0, 0);

        start_dly = 4'd8;
        pulse(0, 1, 0);
        idle(2);
        reset = 1'b1;
        idle(1); expect_out("rst mid", 1, 0, 0, 0);
        reset = 1'b0;
        idle(2);
        stop_seq_dly3("post-rst stop3");

        repeat (3000) begin
            reset     = ($urandom_range(0, 199) == 0);
            stop_req  = ($urandom_range(0, 5) == 0);
            start_req = ($urandom_range(0, 5) == 0);
            step_req  = ($urandom_range(0, 4) == 0);
            stop_dly  = 4'($urandom_range(0, 15));
            start_dly = 4'($urandom_range(0, 15));
            step_len  = 4'($urandom_range(0, 7));
            @(negedge rclk);
        end
        reset = 1'b0;
        stop_req = 1'b0; start_req = 1'b0; step_req = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
